// File: rtl/puf_pkg.sv
// Shared types and challenge field layout for the ring-oscillator pair comparator.
package puf_pkg;

  localparam int CHAL_W  = 6;
  localparam int SEL_MSB = 5;
  localparam int SEL_LSB = 3;
  localparam int BX_MSB  = 2;
  localparam int BX_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_DRAIN,
    ST_COMPARE,
    ST_HOLD
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous RO output into CLK and counts its rising edges,
// saturating at the all-ones value.
module ro_edge_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             CNT_EN,
  input  logic             RO_IN,
  output logic [CNT_W-1:0] COUNT,
  output logic             SAT
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise;

  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign SAT   = &cnt_q;
  assign COUNT = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (CNT_EN && rise && !SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RO_IN};
      prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ro_pair_comparator.sv
// Sequences one PUF challenge over an RO pair: load challenge, settle, gate both
// oscillators for a fixed window, drain the synchronisers, compare and hand off.
//
// state   | meaning
// IDLE    | waiting for START, oscillators disabled
// SETTLE  | challenge applied, waiting before enabling
// COUNT   | RO_EN high, counting edges
// DRAIN   | RO_EN low, letting in-flight synchronised edges land
// COMPARE | registering the comparison result
// HOLD    | RESP_VALID high until RESP_READY
module ro_pair_comparator
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WINDOW      = 1000,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [CHAL_W-1:0] CHAL,
  input  logic              RO_A_IN,
  input  logic              RO_B_IN,
  output logic [2:0]        RO_SEL,
  output logic [2:0]        RO_BX,
  output logic              RO_EN,
  output logic              BUSY,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic              RESP_BIT,
  output logic              RESP_TIE,
  output logic              RESP_OVF,
  output logic [CNT_W-1:0]  CNT_A,
  output logic [CNT_W-1:0]  CNT_B
);

  localparam int unsigned TMR_MAX = max3(WINDOW, SETTLE, SYNC_STAGES + 1);
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              bit_q, bit_d, tie_q, tie_d, ovf_q, ovf_d;
  logic              cnt_clr, cnt_en, sat_a, sat_b, tmr_done;

  assign tmr_done = (tmr_q == '0);

  ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
    .CLK(CLK), .RST(RST), .CLR(cnt_clr), .CNT_EN(cnt_en),
    .RO_IN(RO_A_IN), .COUNT(CNT_A), .SAT(sat_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
    .CLK(CLK), .RST(RST), .CLR(cnt_clr), .CNT_EN(cnt_en),
    .RO_IN(RO_B_IN), .COUNT(CNT_B), .SAT(sat_b)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      chal_q  <= '0;
      bit_q   <= 1'b0;
      tie_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      chal_q  <= chal_d;
      bit_q   <= bit_d;
      tie_q   <= tie_d;
      ovf_q   <= ovf_d;
    end
  end

  // Timer loads N-1 on entry so each phase lasts exactly N cycles.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_done ? '0 : tmr_q - 1'b1;
    chal_d  = chal_q;
    bit_d   = bit_q;
    tie_d   = tie_q;
    ovf_d   = ovf_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SETTLE;
          tmr_d   = TMR_W'(SETTLE - 1);
          chal_d  = CHAL;
          cnt_clr = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          state_d = ST_COUNT;
          tmr_d   = TMR_W'(WINDOW - 1);
        end
      end
      ST_COUNT: begin
        if (tmr_done) begin
          state_d = ST_DRAIN;
          tmr_d   = TMR_W'(SYNC_STAGES);
        end
      end
      ST_DRAIN: begin
        if (tmr_done) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        bit_d   = (CNT_A > CNT_B);
        tie_d   = (CNT_A == CNT_B);
        ovf_d   = sat_a | sat_b;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (RESP_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    RO_SEL     = chal_q[SEL_MSB:SEL_LSB];
    RO_BX      = chal_q[BX_MSB:BX_LSB];
    RO_EN      = (state_q == ST_COUNT);
    BUSY       = (state_q != ST_IDLE);
    RESP_VALID = (state_q == ST_HOLD);
    RESP_BIT   = bit_q;
    RESP_TIE   = tie_q;
    RESP_OVF   = ovf_q;
    cnt_en     = (state_q == ST_COUNT) || (state_q == ST_DRAIN);
  end

endmodule
